// File: rtl/mwadd_seq.sv
// Sequential multi-word add/subtract: drives one 32-bit cla per cycle, carry chained limb to limb.
// Latency WORDS+1 cycles start->done; start is ignored while busy. Subtraction is built only with `MWADD_SUB_EN.

module cla (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ci_i,
  output logic [31:0] sum_o,
  output logic        co_o,
  output logic        ov_o
);
  logic [31:0] g, p;
  logic        cr, c31;

  always_comb begin
    g     = a_i & b_i;
    p     = a_i ^ b_i;
    sum_o = '0;
    cr    = ci_i;
    c31   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) c31 = cr;
      sum_o[i] = p[i] ^ cr;
      cr       = g[i] | (p[i] & cr);
    end
  end

  assign co_o = cr;
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ov_o = cr ^ c31;
endmodule

module mwadd_seq #(
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [32*WORDS-1:0]   a_in,
  input  logic [32*WORDS-1:0]   b_in,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RW = 32 * WORDS;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            c_q, sub_q;
  logic [RW-1:0]   a_q, b_q, result_q;
  logic            carry_q, ovf_q, zero_q, busy_q, done_q;

  logic            sub_d, last;
  logic [31:0]     a_limb, b_limb, b_fmt, sum;
  logic            cla_co, cla_ov;

`ifdef MWADD_SUB_EN
  assign sub_d = op_sub;
`else
  // Port stays for pin compatibility; every request is an add.
  assign sub_d = op_sub & 1'b0;
`endif

  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IW'(k)) begin
        a_limb = a_q[k*32 +: 32];
        b_limb = b_q[k*32 +: 32];
      end
    end
  end

  assign b_fmt = sub_q ? ~b_limb : b_limb;
  assign last  = (idx_q == IW'(WORDS - 1));

  cla u_cla (
    .a_i   (a_limb),
    .b_i   (b_fmt),
    .ci_i  (c_q),
    .sum_o (sum),
    .co_o  (cla_co),
    .ov_o  (cla_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      c_q      <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            sub_q   <= sub_d;
            c_q     <= sub_d;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IW'(k)) result_q[k*32 +: 32] <= sum;
          end
          c_q <= cla_co;
          if (last) begin
            carry_q <= cla_co;
            ovf_q   <= cla_ov;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          // Result is complete here, so zero lands in the same cycle as the done pulse.
          zero_q  <= (result_q == '0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_mwadd_seq.sv
// Bench for mwadd_seq: arithmetic reference model checked every cycle, plus literal directed cases.
module tb_mwadd_seq;
  localparam int W  = 2;
  localparam int RW = 32 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op_sub = 1'b0;
  logic [RW-1:0] a_in = '0;
  logic [RW-1:0] b_in = '0;
  logic          busy, done, carry_out, overflow, zero;
  logic [RW-1:0] result;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mwadd_seq #(.WORDS(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic chkw(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end else passes++;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end else passes++;
  endtask

  // Full-width reference: {carry, overflow, zero, result}.
  function automatic logic [RW+2:0] model(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                          input logic sub);
    logic          s;
    logic [RW-1:0] bb;
    logic [RW:0]   t;
    logic          v;
    s = sub;
`ifndef MWADD_SUB_EN
    s = 1'b0;
`endif
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{RW{1'b0}}, s};
    v  = (a[RW-1] == bb[RW-1]) && (t[RW-1] != a[RW-1]);
    return {t[RW], v, (t[RW-1:0] == '0), t[RW-1:0]};
  endfunction

  function automatic logic [RW-1:0] rnd();
    logic [RW-1:0] v;
    v = '0;
    case ($urandom_range(0, 4))
      0: v = '0;
      1: v = '1;
      2: v = {1'b0, {(RW-1){1'b1}}};
      3: v = RW'($urandom_range(0, 7));
      default: for (int i = 0; i < W; i++) v[i*32 +: 32] = $urandom;
    endcase
    return v;
  endfunction

  // Model state: ph counts cycles since the accepting edge (0 = first RUN cycle).
  bit            have_op;
  int            ph;
  logic [RW-1:0] er;
  logic          ec, ev, ez;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_op <= 1'b0;
      ph      <= 0;
      er      <= '0;
      ec      <= 1'b0;
      ev      <= 1'b0;
      ez      <= 1'b0;
    end else if (start && (!have_op || ph >= W + 1)) begin
      {ec, ev, ez, er} <= model(a_in, b_in, op_sub);
      have_op <= 1'b1;
      ph      <= 0;
    end else if (have_op && ph < 1000) begin
      ph <= ph + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chkw("rst_result", result, '0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_carry", carry_out, 1'b0);
      chk1("rst_ovf", overflow, 1'b0);
      chk1("rst_zero", zero, 1'b0);
    end else if (have_op && ph < W) begin
      chk1("run_busy", busy, 1'b1);
      chk1("run_done", done, 1'b0);
      chk1("run_carry", carry_out, 1'b0);
      chk1("run_ovf", overflow, 1'b0);
      chk1("run_zero", zero, 1'b0);
    end else if (have_op && ph == W) begin
      chk1("last_busy", busy, 1'b1);
      chk1("last_done", done, 1'b0);
      chk1("last_carry", carry_out, ec);
      chk1("last_ovf", overflow, ev);
      chk1("last_zero", zero, 1'b0);
    end else begin
      chk1("idle_done", done, have_op && ph == W + 1);
      if (!(have_op && ph == W + 1)) chk1("idle_busy", busy, 1'b0);
      chkw("idle_result", result, er);
      chk1("idle_carry", carry_out, ec);
      chk1("idle_ovf", overflow, ev);
      chk1("idle_zero", zero, ez);
    end
  end

  // Called and returns at negedge+2; optional start noise while busy.
  task automatic run_op(input string nm, input logic [RW-1:0] a, input logic [RW-1:0] b,
                        input logic sub, input bit noisy, input logic [RW-1:0] xr,
                        input logic xc, input logic xv, input logic xz);
    bit seen;
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    op_sub = sub;
    @(negedge clk);
    #2;
    start = noisy;
    if (noisy) begin a_in = rnd(); b_in = rnd(); op_sub = 1'(~sub); end
    seen = 1'b0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chkw({nm, "_latency"}, RW'(k), RW'(W + 1));
        chkw({nm, "_result"}, result, xr);
        chk1({nm, "_carry"}, carry_out, xc);
        chk1({nm, "_ovf"}, overflow, xv);
        chk1({nm, "_zero"}, zero, xz);
        #2;
        start = 1'b0;
      end else begin
        #2;
        start = noisy && (k <= W);
        if (noisy) begin a_in = rnd(); b_in = rnd(); end
      end
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: done not seen, required within 12 cycles", nm);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chkw("reset_result_lit", result, '0);
    #2;
    rst_n = 1'b1;

    run_op("add_lo_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
`ifdef MWADD_SUB_EN
    run_op("sub_5_7", 64'd5, 64'd7, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_7_5", 64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0, 1'b0);
`else
    run_op("nosub_7_5", 64'd7, 64'd5, 1'b1, 1'b0, 64'd12, 1'b0, 1'b0, 1'b0);
`endif
    run_op("noisy_9_10", 64'd9, 64'd10, 1'b0, 1'b1, 64'd19, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an operation, after limb 0 has been written.
    start  = 1'b1;
    a_in   = 64'd100;
    b_in   = 64'd200;
    op_sub = 1'b0;
    @(negedge clk);
    #2;
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chkw("midrun_rst_result", result, '0);
    chk1("midrun_rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    run_op("after_rst_3_4", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);

    repeat (400) begin
      start  = ($urandom_range(0, 2) == 0);
      a_in   = rnd();
      b_in   = rnd();
      op_sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      #2;
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mwadd_seq.md
# mwadd_seq

Sequential multi-word add/subtract unit that drives the team's 32-bit carry-look-ahead adder (`cla`) once per cycle, chaining carry between limbs to produce a 32·WORDS-bit result. It sits directly upstream of one `cla` instance. It owns operand staging, limb sequencing, subtract formatting and flag capture. The adder only provides 32-bit combinational sum, carry-out and overflow.

## Interface
- WORDS, 2, number of 32-bit limbs; legal range 1..8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- op_sub  in  1  0 = A+B, 1 = A−B; sampled with start
- a_in  in  32·WORDS  operand A; limb 0 = bits [31:0]; sampled with start
- b_in  in  32·WORDS  operand B; sampled with start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse when result and flags are valid
- result  out  32·WORDS  sum/difference register
- carry_out  out  1  carry out of top limb (subtract: 1 = no borrow)
- overflow  out  1  signed overflow of full-width operation
- zero  out  1  result == 0

## Operation
- States: IDLE, RUN, DONE. Limb index idx, width ⌈log2 WORDS⌉ (min 1). Carry register c.
- IDLE:
  - On start=1, latch a_in, b_in and op_sub.
  - Set c := op_sub, idx := 0, clear carry_out, overflow and zero, go to RUN.
  - result is not cleared.
- RUN, per cycle:
  - Drive the `cla` inputs: a = A[idx], b = op_sub ? ~B[idx] : B[idx], carry_in = c.
  - Write the `cla` sum into result limb idx. Set c := `cla` carry_out.
  - If idx == WORDS−1, capture carry_out and overflow from `cla`, then go to DONE. Otherwise idx := idx+1.
- DONE:
  - done=1 for exactly one cycle.
  - zero is registered from the final result in this state, so it is valid together with done.
  - Return to IDLE.
- start is ignored in RUN and DONE. There is no queueing.
- Outputs hold their values in IDLE until the next accepted start.
- Width rules:
  - Limb arithmetic is modulo 2^32.
  - The full result is modulo 2^(32·WORDS).
  - overflow is the signed overflow of the top limb only, which equals full-width signed overflow.
- Reset, asserted at any time including mid-RUN:
  - Immediately forces IDLE.
  - Clears idx, c and latched operands.
  - result, carry_out, overflow, zero, busy and done all go to 0.

## Timing
- If start is sampled at edge T0, RUN occupies edges T1..T_WORDS. done and valid flags are high in the cycle after edge T_WORDS+1.
- Latency from start to done is WORDS+1 cycles. Throughput is one operation per WORDS+2 cycles.
- start high in the DONE cycle is ignored. start high in the first IDLE cycle after DONE is accepted.
- busy rises in the cycle after start is accepted and falls together with done.
- WORDS=1: a single RUN cycle, then DONE.

## Configuration
- MWADD_SUB_EN defined: subtraction is supported as described above.
- MWADD_SUB_EN undefined:
  - op_sub is ignored and treated as 0; the port remains present.
  - No B inversion and no carry seed; every request performs A+B.

## Test plan
All scenarios use WORDS=2 and MWADD_SUB_EN defined unless stated.
- Add 0x00000000_FFFFFFFF + 0x1 -> result 0x00000001_00000000, carry_out=0, overflow=0, zero=0; done exactly 3 cycles after start.
- Add 0xFFFFFFFF_FFFFFFFF + 0x1 -> result 0, carry_out=1, overflow=0, zero=1.
- Add 0x7FFFFFFF_FFFFFFFF + 0x1 -> result 0x80000000_00000000, overflow=1, carry_out=0.
- Sub 5−7 -> 0xFFFFFFFF_FFFFFFFE, carry_out=0, overflow=0. Sub 7−5 -> 0x2, carry_out=1.
- Start pulses during RUN and DONE are ignored; reset asserted mid-RUN clears all outputs and returns to IDLE; the next start of 3+4 yields 7.
- MWADD_SUB_EN undefined: op_sub=1 with 7, 5 -> result 12, carry_out=0.
